// File: rtl/radar_scan_ctrl_if.sv
// Sample port of the radar scan controller: one (angle, distance, timeout) record per valid/ready handshake.
interface radar_scan_ctrl_if #(
  parameter int DIST_W = 16
) ();
  logic              sample_valid;
  logic              sample_ready;
  logic [7:0]        sample_angle;
  logic [DIST_W-1:0] sample_dist;
  logic              sample_timeout;

  modport master (
    output sample_valid, sample_angle, sample_dist, sample_timeout,
    input  sample_ready
  );

  modport slave (
    input  sample_valid, sample_angle, sample_dist, sample_timeout,
    output sample_ready
  );
endinterface

// File: rtl/radar_scan_ctrl.sv
// Servo sweep and ultrasonic ping sequencer producing (angle, distance) samples.
// Macro RADAR_BOUNCE_EN selects a ping-pong sweep; undefined gives a wrap-around sweep.
module radar_scan_ctrl #(
  parameter int STEPS         = 12,
  parameter int SETTLE_CYCLES = 2_000_000,
  parameter int TRIG_CYCLES   = 1000,
  parameter int ECHO_TIMEOUT  = 3_000_000,
  parameter int CM_CYCLES     = 5800,
  parameter int DIST_W        = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stop,
  input  logic              echo,
  output logic              trigger,
  output logic [7:0]        angle_idx,
  output logic              busy,
  output logic              sweep_done,
  radar_scan_ctrl_if.master smp
);
  localparam int PH_MAX = (SETTLE_CYCLES > TRIG_CYCLES) ? SETTLE_CYCLES : TRIG_CYCLES;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int SUB_W  = $clog2(CM_CYCLES + 1);
  localparam int TMO_W  = $clog2(ECHO_TIMEOUT + 1);
  localparam logic [7:0] LAST = 8'(STEPS - 1);

  typedef enum logic [2:0] {IDLE, SETTLE, TRIG, WAIT_RISE, MEASURE, EMIT, STEP} state_t;

  state_t            state_r, state_s;
  logic              echo_meta_r, echo_sync_r, echo_s;
  logic [PH_W-1:0]   ph_cnt_r;
  logic [TMO_W-1:0]  tmo_r;
  logic [SUB_W-1:0]  sub_r;
  logic [DIST_W-1:0] dist_r;
  logic [7:0]        angle_r, angle_nx_s;
  logic              stop_r, first_r;
  logic              hs_s, emit_meas_s, emit_tmo_s, end_hit_s;
  logic              trigger_r, busy_r, valid_r, sweep_r, tmo_out_r;
  logic [7:0]        angle_out_r;
  logic [DIST_W-1:0] dist_out_r;
`ifdef RADAR_BOUNCE_EN
  logic              dir_r, dir_nx_s;
`endif

  // Two-flop synchronizer for the asynchronous echo input
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      echo_meta_r <= 1'b0;
      echo_sync_r <= 1'b0;
    end else begin
      echo_meta_r <= echo;
      echo_sync_r <= echo_meta_r;
    end
  end
  assign echo_s = echo_sync_r;

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_r <= IDLE;
    else       state_r <= state_s;
  end

  // FSM next-state logic and emit qualifiers
  always_comb begin
    state_s     = state_r;
    hs_s        = valid_r & smp.sample_ready;
    emit_meas_s = 1'b0;
    emit_tmo_s  = 1'b0;
    case (state_r)
      IDLE:   if (start) state_s = SETTLE; else state_s = IDLE;
      SETTLE: if (ph_cnt_r == PH_W'(SETTLE_CYCLES - 1)) state_s = TRIG; else state_s = SETTLE;
      TRIG:   if (ph_cnt_r == PH_W'(TRIG_CYCLES - 1)) state_s = WAIT_RISE; else state_s = TRIG;
      WAIT_RISE: begin
        if (tmo_r == TMO_W'(ECHO_TIMEOUT)) begin
          state_s    = EMIT;
          emit_tmo_s = 1'b1;
        end else if (echo_s) begin
          state_s = MEASURE;
        end else begin
          state_s = WAIT_RISE;
        end
      end
      MEASURE: begin
        // A falling edge wins over a simultaneous timeout: the measurement is complete
        if (!echo_s) begin
          state_s     = EMIT;
          emit_meas_s = 1'b1;
        end else if (tmo_r == TMO_W'(ECHO_TIMEOUT)) begin
          state_s    = EMIT;
          emit_tmo_s = 1'b1;
        end else begin
          state_s = MEASURE;
        end
      end
      EMIT:   if (hs_s) state_s = STEP; else state_s = EMIT;
      STEP:   if (stop_r || stop) state_s = IDLE; else state_s = SETTLE;
      default: state_s = IDLE;
    endcase
  end

  // Next sweep position and end-of-sweep detection
  always_comb begin
    angle_nx_s = angle_r;
    end_hit_s  = 1'b0;
`ifdef RADAR_BOUNCE_EN
    dir_nx_s   = dir_r;
    if (dir_r) begin
      if (angle_r == LAST) begin
        angle_nx_s = angle_r - 8'd1;
        dir_nx_s   = 1'b0;
      end else begin
        angle_nx_s = angle_r + 8'd1;
        dir_nx_s   = 1'b1;
      end
    end else begin
      if (angle_r == 8'd0) begin
        angle_nx_s = angle_r + 8'd1;
        dir_nx_s   = 1'b1;
      end else begin
        angle_nx_s = angle_r - 8'd1;
        dir_nx_s   = 1'b0;
      end
    end
    end_hit_s = (angle_out_r == 8'd0) || (angle_out_r == LAST);
`else
    if (angle_r == LAST) angle_nx_s = 8'd0;
    else                 angle_nx_s = angle_r + 8'd1;
    end_hit_s = (angle_out_r == LAST);
`endif
  end

  // Phase, timeout and echo-width counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ph_cnt_r <= '0;
      tmo_r    <= '0;
      sub_r    <= '0;
      dist_r   <= '0;
    end else begin
      if (state_s != state_r) ph_cnt_r <= '0;
      else                    ph_cnt_r <= ph_cnt_r + PH_W'(1);
      if (state_r == WAIT_RISE || state_r == MEASURE) tmo_r <= tmo_r + TMO_W'(1);
      else                                            tmo_r <= '0;
      // The rise-detect cycle in WAIT_RISE already counts as echo-high time
      if (state_s == TRIG) begin
        sub_r  <= '0;
        dist_r <= '0;
      end else if ((state_r == WAIT_RISE || state_r == MEASURE) && echo_s) begin
        if (sub_r == SUB_W'(CM_CYCLES - 1)) begin
          sub_r <= '0;
          if (dist_r != '1) dist_r <= dist_r + DIST_W'(1);
        end else begin
          sub_r <= sub_r + SUB_W'(1);
        end
      end
    end
  end

  // Sweep position, stop latch and first-sample-after-start marker
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      angle_r <= 8'd0;
      stop_r  <= 1'b0;
      first_r <= 1'b0;
    end else begin
      if (state_r == IDLE) begin
        if (start) begin
          stop_r  <= 1'b0;
          first_r <= 1'b1;
        end
      end else begin
        if (stop) stop_r  <= 1'b1;
        if (hs_s) first_r <= 1'b0;
      end
      if (state_r == STEP) angle_r <= angle_nx_s;
    end
  end

`ifdef RADAR_BOUNCE_EN
  // Sweep direction register (1 = increasing index)
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 dir_r <= 1'b1;
    else if (state_r == STEP)  dir_r <= dir_nx_s;
  end
`endif

  // Registered outputs and sample holding registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trigger_r   <= 1'b0;
      busy_r      <= 1'b0;
      valid_r     <= 1'b0;
      sweep_r     <= 1'b0;
      tmo_out_r   <= 1'b0;
      angle_out_r <= 8'd0;
      dist_out_r  <= '0;
    end else begin
      trigger_r <= (state_s == TRIG);
      busy_r    <= (state_s != IDLE);
      valid_r   <= (state_s == EMIT);
      sweep_r   <= hs_s & end_hit_s & ~first_r;
      if (emit_meas_s) begin
        angle_out_r <= angle_r;
        dist_out_r  <= dist_r;
        tmo_out_r   <= 1'b0;
      end else if (emit_tmo_s) begin
        angle_out_r <= angle_r;
        dist_out_r  <= '1;
        tmo_out_r   <= 1'b1;
      end
    end
  end

  assign trigger            = trigger_r;
  assign busy               = busy_r;
  assign angle_idx          = angle_r;
  assign sweep_done         = sweep_r;
  assign smp.sample_valid   = valid_r;
  assign smp.sample_angle   = angle_out_r;
  assign smp.sample_dist    = dist_out_r;
  assign smp.sample_timeout = tmo_out_r;
endmodule

// File: tb/tb_radar_scan_ctrl.sv
// Directed self-checking bench for radar_scan_ctrl (STEPS=4, SETTLE=10, TRIG=5, TIMEOUT=100, CM=3).
module tb_radar_scan_ctrl;
  localparam int DW = 16;

  logic       clk = 1'b0;
  logic       reset, start, stop, echo;
  logic       trigger, busy, sweep_done;
  logic [7:0] angle_idx;
  int         n_tests = 0;
  int         n_fail  = 0;

  int lat, w, n;
  logic [7:0]  a;
  logic [15:0] d;
  logic        t, sd, stable;
  int exp_ang [10];
  int exp_sd  [10];
  int exp_dist[10];
  int lens    [10];

  radar_scan_ctrl_if #(.DIST_W(DW)) smp ();

  radar_scan_ctrl #(
    .STEPS(4), .SETTLE_CYCLES(10), .TRIG_CYCLES(5),
    .ECHO_TIMEOUT(100), .CM_CYCLES(3), .DIST_W(DW)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .echo(echo),
    .trigger(trigger), .angle_idx(angle_idx), .busy(busy),
    .sweep_done(sweep_done), .smp(smp)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // From the current negedge: cycles until trigger rises, then its high width
  task automatic trig_cycle(output int lat_o, output int width_o);
    lat_o = 0;
    width_o = 0;
    while (trigger !== 1'b1 && lat_o < 400) begin
      @(negedge clk);
      lat_o++;
    end
    if (trigger !== 1'b1) check_val("trig_rise_wait", trigger, 1'b1);
    while (trigger === 1'b1 && width_o < 400) begin
      @(negedge clk);
      width_o++;
    end
  endtask

  task automatic wait_valid(output int n_o);
    n_o = 0;
    while (smp.sample_valid !== 1'b1 && n_o < 500) begin
      @(negedge clk);
      n_o++;
    end
    if (smp.sample_valid !== 1'b1) check_val("valid_wait", smp.sample_valid, 1'b1);
  endtask

  // Drive an echo of len cycles (stop pulsed at cycle stop_at), then capture the sample
  task automatic collect(input int len, input int stop_at, output logic [7:0] a_o,
                         output logic [15:0] d_o, output logic t_o, output logic sd_o);
    int nv;
    repeat (2) @(negedge clk);
    echo = 1'b1;
    for (int i = 0; i < len; i++) begin
      stop = (i == stop_at);
      @(negedge clk);
    end
    echo = 1'b0;
    stop = 1'b0;
    wait_valid(nv);
    a_o = smp.sample_angle;
    d_o = smp.sample_dist;
    t_o = smp.sample_timeout;
    @(negedge clk);
    sd_o = sweep_done;
  endtask

  initial begin
`ifdef RADAR_BOUNCE_EN
    exp_ang = '{0, 1, 2, 3, 2, 1, 0, 1, 2, 3};
    exp_sd  = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 0};
`else
    exp_ang = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 1};
    exp_sd  = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0};
`endif
    lens     = '{30, 0, 9, 3, 8, 1, 12, 5, 12, 6};
    exp_dist = '{10, 65535, 3, 1, 2, 0, 4, 1, 4, 2};

    reset = 1'b1; start = 1'b0; stop = 1'b0; echo = 1'b0;
    smp.sample_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_val("rst_trigger", trigger, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_valid", smp.sample_valid, 1'b0);
    check_val("rst_angle_idx", angle_idx, 8'd0);
    check_val("rst_sample_dist", smp.sample_dist, 16'd0);
    check_val("rst_timeout", smp.sample_timeout, 1'b0);
    check_val("rst_sweep_done", sweep_done, 1'b0);
    reset = 1'b0;
    @(negedge clk);

    // Sample 0: basic measurement with trigger timing
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_val("busy_after_start", busy, 1'b1);
    trig_cycle(lat, w);
    check_val("settle_latency", lat, 32'd10);
    check_val("trig_width", w, 32'd5);
    collect(lens[0], -1, a, d, t, sd);
    check_val("s0_angle", a, exp_ang[0]);
    check_val("s0_dist", d, exp_dist[0]);
    check_val("s0_timeout", t, 1'b0);
    check_val("s0_sweep_done", sd, exp_sd[0]);

    // Sample 1: no echo, timeout 100 cycles after trigger fall plus one
    trig_cycle(lat, w);
    check_val("s1_trig_width", w, 32'd5);
    wait_valid(n);
    check_val("s1_timeout_latency", n, 32'd101);
    check_val("s1_angle", smp.sample_angle, exp_ang[1]);
    check_val("s1_dist", smp.sample_dist, exp_dist[1]);
    check_val("s1_timeout", smp.sample_timeout, 1'b1);
    @(negedge clk);
    check_val("s1_sweep_done", sweep_done, exp_sd[1]);

    // Sample 2: backpressure for 50 cycles
    smp.sample_ready = 1'b0;
    trig_cycle(lat, w);
    collect(lens[2], -1, a, d, t, sd);
    check_val("s2_angle", a, exp_ang[2]);
    check_val("s2_dist", d, exp_dist[2]);
    check_val("s2_timeout", t, 1'b0);
    stable = 1'b1;
    repeat (50) begin
      @(negedge clk);
      if (smp.sample_valid !== 1'b1 || smp.sample_angle !== a ||
          smp.sample_dist !== d || smp.sample_timeout !== t) stable = 1'b0;
    end
    check_val("bp_hold_stable", stable, 1'b1);
    smp.sample_ready = 1'b1;
    @(negedge clk);
    check_val("bp_single_sample", smp.sample_valid, 1'b0);
    check_val("bp_angle_not_yet", angle_idx, exp_ang[2]);
    check_val("s2_sweep_done", sweep_done, exp_sd[2]);
    @(negedge clk);
    check_val("bp_angle_advanced", angle_idx, exp_ang[3]);

    // Samples 3..7: sweep order and sweep_done
    for (int k = 3; k < 8; k++) begin
      trig_cycle(lat, w);
      collect(lens[k], -1, a, d, t, sd);
      check_val($sformatf("s%0d_angle", k), a, exp_ang[k]);
      check_val($sformatf("s%0d_dist", k), d, exp_dist[k]);
      check_val($sformatf("s%0d_timeout", k), t, 1'b0);
      check_val($sformatf("s%0d_sweep_done", k), sd, exp_sd[k]);
    end

    // Sample 8: stop pulsed during MEASURE
    trig_cycle(lat, w);
    collect(lens[8], 5, a, d, t, sd);
    check_val("s8_angle", a, exp_ang[8]);
    check_val("s8_dist", d, exp_dist[8]);
    check_val("s8_sweep_done", sd, exp_sd[8]);
    repeat (3) @(negedge clk);
    check_val("stop_idle_busy", busy, 1'b0);
    check_val("stop_angle_idx", angle_idx, exp_ang[9]);
    repeat (20) @(negedge clk);
    check_val("stop_stays_idle", {busy, trigger}, 2'b00);

    // Sample 9: restart resumes from stored angle
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    trig_cycle(lat, w);
    check_val("resume_settle_latency", lat, 32'd10);
    collect(lens[9], -1, a, d, t, sd);
    check_val("s9_angle", a, exp_ang[9]);
    check_val("s9_dist", d, exp_dist[9]);
    check_val("s9_sweep_done_first", sd, exp_sd[9]);

    // Reset asserted while trigger is high
    n = 0;
    while (trigger !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_val("pre_reset_trigger", trigger, 1'b1);
    #2 reset = 1'b1;
    #1;
    check_val("arst_trigger", trigger, 1'b0);
    check_val("arst_busy", busy, 1'b0);
    check_val("arst_valid", smp.sample_valid, 1'b0);
    check_val("arst_angle_idx", angle_idx, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_val("post_reset_busy", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/radar_scan_ctrl.md
# radar_scan_ctrl

Sequencer for the radar front end. Steps the servo through `STEPS` angle positions, waits for mechanical settling at each one, then fires one ultrasonic ping: it drives `trigger`, times `echo` and converts the pulse width to centimetres. Each result goes out as an (angle, distance) sample on a valid/ready port for the display or UART layer.

## Interface
Parameters:
- `STEPS`, 12: number of angle positions, 2..255.
- `SETTLE_CYCLES`, 2_000_000: servo settle time after each angle change (20 ms at 100 MHz).
- `TRIG_CYCLES`, 1000: trigger high width (10 us).
- `ECHO_TIMEOUT`, 3_000_000: cycles allowed from trigger fall to echo fall.
- `CM_CYCLES`, 5800: echo-high cycles per centimetre.
- `DIST_W`, 16: distance width.

Ports:
- `clk`, in, 1: system clock. Single clock domain.
- `reset`, in, 1: asynchronous, active-high reset.
- `start`, in, 1: one-cycle pulse that begins scanning. Ignored while `busy`.
- `stop`, in, 1: level or pulse. Latched; takes effect after the current sample handshake.
- `echo`, in, 1: raw sensor echo, asynchronous. Synchronized internally.
- `trigger`, out, 1: sensor trigger.
- `angle_idx`, out, 8: commanded servo position, for the servo PWM block.
- `busy`, out, 1: high in any state except IDLE.
- `sample_valid`, out, 1: sample available.
- `sample_ready`, in, 1: consumer accepts the sample.
- `sample_angle`, out, 8: angle index of the sample.
- `sample_dist`, out, DIST_W: distance in cm. All ones on timeout or saturation.
- `sample_timeout`, out, 1: no valid echo within `ECHO_TIMEOUT`.
- `sweep_done`, out, 1: one-cycle pulse when the sample at an end position is accepted.

## Operation
- Reset values:
  - `trigger`, `busy`, `sample_valid`, `sample_timeout`, `sweep_done` = 0.
  - `angle_idx`, `sample_angle`, `sample_dist` = 0.
  - Direction = up, stop latch = 0, state = IDLE.
- `echo` passes through a 2-flop synchronizer; `echo_s` is the synchronized signal. All echo decisions use `echo_s`.
- States:
  - IDLE. On `start`: clear the stop latch, go to SETTLE. `angle_idx` keeps its current value.
  - SETTLE. Count `SETTLE_CYCLES` cycles, then go to TRIG.
  - TRIG. `trigger` = 1 for exactly `TRIG_CYCLES` cycles, then go to WAIT_RISE. The timeout counter starts at 0.
  - WAIT_RISE. Go to MEASURE when `echo_s` = 1.
  - MEASURE:
    - Each cycle with `echo_s` = 1, a sub-counter increments.
    - When the sub-counter reaches `CM_CYCLES`-1, it wraps to 0 and `dist` increments, saturating at all ones.
    - When `echo_s` falls, go to EMIT with timeout = 0.
  - Timeout:
    - The counter runs through WAIT_RISE and MEASURE.
    - On reaching `ECHO_TIMEOUT`, go to EMIT with `sample_timeout` = 1 and `sample_dist` = all ones.
  - EMIT:
    - `sample_valid` = 1. `sample_angle`, `sample_dist` and `sample_timeout` are stable while valid is high.
    - The handshake completes on a cycle with `sample_valid` && `sample_ready`.
    - The next cycle, `sample_valid` = 0 and the block goes to STEP.
  - STEP:
    - Compute the next angle (see Configuration) and update `angle_idx`.
    - If the stop latch is set, go to IDLE. Otherwise go to SETTLE.
- Stop:
  - `stop` is sampled in every state except IDLE and sets the latch.
  - The in-flight measurement always completes and is delivered.
- If `start` and `stop` are asserted in the same IDLE cycle, `start` wins and the latch is cleared.
- Reset mid-operation: all outputs return to their reset values asynchronously, including `trigger`. A pending sample is discarded.
- If `echo_s` is already high on entry to WAIT_RISE (stale echo), it counts as a rise. There is no special handling.
- `dist` and the sub-counter clear on entry to TRIG.

## Timing
- Trigger:
  - `trigger` rises exactly `SETTLE_CYCLES` cycles after SETTLE entry.
  - It stays high exactly `TRIG_CYCLES` cycles.
- Echo-to-state latency is 2 cycles (synchronizer) plus 1 cycle of registered state.
- `sample_valid` asserts 1 cycle after the echo_s fall or timeout is detected.
- `sample_valid` may be held indefinitely by `sample_ready` = 0. No samples are dropped.
- The consumer may hold `sample_ready` high permanently. Each handshake then takes exactly 1 cycle.
- `angle_idx` updates 2 cycles after the handshake, registered in STEP.
- `sweep_done` pulses 1 cycle after the handshake of a sample at index 0 or `STEPS`-1, excluding the very first sample after `start`.

## Configuration
- `RADAR_BOUNCE_EN` defined: ping-pong sweep.
  - Moving up, `STEPS`-1 reverses the direction.
  - Moving down, 0 reverses the direction.
  - No end index is repeated. Sequence for STEPS=4: 0,1,2,3,2,1,0,1…
- `RADAR_BOUNCE_EN` undefined: wrap sweep.
  - After `STEPS`-1 the next index is 0. Direction is always up.
  - `sweep_done` pulses only at `STEPS`-1.

## Test plan
Bench parameters: STEPS=4, SETTLE=10, TRIG=5, TIMEOUT=100, CM=3.
- Basic measurement: `start`, echo high 30 cycles, ready=1 → `trigger` high 5 cycles; sample angle 0, dist 10, timeout 0.
- No echo: echo held 0 → `sample_timeout`=1 and dist=16'hFFFF, 100 cycles after trigger fall plus 1 cycle.
- Backpressure: ready=0 for 50 cycles → valid stays high with fields stable. Exactly one sample on release; `angle_idx` advances 2 cycles after release.
- Sweep order: 8 samples.
  - With `RADAR_BOUNCE_EN`, angles 0,1,2,3,2,1,0,1 and `sweep_done` after angles 3 and 0.
  - Without it, angles 0,1,2,3,0,1,2,3.
- Stop mid-measurement: `stop` pulsed during MEASURE → that sample is delivered, then IDLE with `busy`=0. A following `start` resumes from the stored `angle_idx`.
- Reset mid-trigger: `reset` asserted while `trigger`=1 → `trigger`, `busy` and `sample_valid` are 0 the same cycle, and `angle_idx`=0.
